// File: rtl/serial_parity_checker.sv
// Framed serial parity checker.
// Accepts DATA_W data bits (LSB first) followed by one parity bit on a
// 1-bit serial input qualified by i_valid, checks the frame against the
// even/odd mode latched at i_start, and reports the result.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_start    begin a new frame (aborts any frame in progress)
//   i_valid    i_x carries a bit this cycle
//   i_x        serial bit, LSB first
//   i_odd      parity mode sampled on i_start (0 = even, 1 = odd)
//   o_p        Mealy running parity (combinational)
//   o_busy     frame in progress
//   o_done     one-cycle pulse after the parity bit is accepted
//   o_err      parity mismatch of the last completed frame
//   o_err_cnt  saturating count of mismatched frames
//   o_word     data bits of the last completed frame
module serial_parity_checker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic              i_x,
  input  logic              i_odd,
  output logic              o_p,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [DATA_W-1:0] o_word
);

  // Bit index only has to reach DATA_W-1; keep at least one bit for DATA_W=1.
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                acc;
  logic                mode;
  logic [IDX_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shift;
  logic                last_bit_c;
  logic                par_c;
  logic                err_c;
  logic                take_bit_c;
  logic                take_par_c;

  assign last_bit_c = (bit_cnt == IDX_W'(DATA_W - 1));
  assign par_c      = acc ^ i_x;
  assign err_c      = (par_c != mode);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; i_start restarts the frame from any state.
  always_comb begin
    state_nxt = state;
    if (i_start) begin
      state_nxt = DATA;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        DATA:    if (i_valid && last_bit_c) state_nxt = PARITY;
        PARITY:  if (i_valid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / strobe logic; a bit arriving with i_start is not consumed.
  always_comb begin
    o_p        = 1'b0;
    take_bit_c = 1'b0;
    take_par_c = 1'b0;
    if ((state != IDLE) && i_valid) begin
      o_p = ~(par_c ^ mode);
    end
    if (!i_start) begin
      case (state)
        DATA:    take_bit_c = i_valid;
        PARITY:  take_par_c = i_valid;
        default: begin
          take_bit_c = 1'b0;
          take_par_c = 1'b0;
        end
      endcase
    end
  end

  assign o_busy = (state != IDLE);

  // Frame datapath: running parity, bit index, captured data bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc     <= 1'b0;
      mode    <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
    end else if (i_start) begin
      acc     <= 1'b0;
      mode    <= i_odd;
      bit_cnt <= '0;
    end else if (take_bit_c) begin
      acc     <= par_c;
      bit_cnt <= bit_cnt + IDX_W'(1);
      for (int i = 0; i < int'(DATA_W); i++) begin
        if (bit_cnt == IDX_W'(i)) begin
          shift[i] <= i_x;
        end
      end
    end
  end

  // Completed-frame results; counter saturates at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
      o_word    <= '0;
    end else begin
      o_done <= take_par_c;
      if (take_par_c) begin
        o_err  <= err_c;
        o_word <= shift;
        if (err_c && (o_err_cnt != {CNT_W{1'b1}})) begin
          o_err_cnt <= o_err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst, start, valid, x, odd;

  always #5 clk = ~clk;

  // Three configurations driven by the same stimulus.
  logic       p0, busy0, done0, err0;
  logic [7:0] cnt0, word0;
  logic       p1, busy1, done1, err1;
  logic [1:0] cnt1;
  logic [7:0] word1;
  logic       p2, busy2, done2, err2;
  logic [7:0] cnt2;
  logic [0:0] word2;

  serial_parity_checker #(.DATA_W(8), .CNT_W(8)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .i_x(x), .i_odd(odd),
    .o_p(p0), .o_busy(busy0), .o_done(done0), .o_err(err0), .o_err_cnt(cnt0), .o_word(word0));
  serial_parity_checker #(.DATA_W(8), .CNT_W(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .i_x(x), .i_odd(odd),
    .o_p(p1), .o_busy(busy1), .o_done(done1), .o_err(err1), .o_err_cnt(cnt1), .o_word(word1));
  serial_parity_checker #(.DATA_W(1), .CNT_W(8)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .i_x(x), .i_odd(odd),
    .o_p(p2), .o_busy(busy2), .o_done(done2), .o_err(err2), .o_err_cnt(cnt2), .o_word(word2));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame tracked as a ones count and a list of received bits.
  int         dw [3] = '{8, 8, 1};
  int         cw [3] = '{8, 2, 8};
  bit         m_busy [3];
  bit         m_mode [3];
  bit         m_done [3];
  bit         m_err  [3];
  int         m_ones [3];
  int         m_nb   [3];
  int         m_cnt  [3];
  logic [7:0] m_bits [3];
  logic [7:0] m_word [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic p, input logic busy, input logic done,
                            input logic err, input logic [31:0] cnt, input logic [31:0] word);
    logic [31:0] mask;
    bit          exp_p;
    mask  = (32'd1 << dw[k]) - 32'd1;
    exp_p = (m_busy[k] && valid) ? (((m_ones[k] + int'(x)) % 2) == int'(m_mode[k])) : 1'b0;
    check($sformatf("u%0d_p", k),    32'(p),    32'(exp_p));
    check($sformatf("u%0d_busy", k), 32'(busy), 32'(m_busy[k]));
    check($sformatf("u%0d_done", k), 32'(done), 32'(m_done[k]));
    check($sformatf("u%0d_err", k),  32'(err),  32'(m_err[k]));
    check($sformatf("u%0d_cnt", k),  cnt,       32'(m_cnt[k]));
    check($sformatf("u%0d_word", k), word,      32'(m_word[k]) & mask);
  endtask

  task automatic model_update(input int k);
    bit e;
    m_done[k] = 1'b0;
    if (rst) begin
      m_busy[k] = 0; m_mode[k] = 0; m_err[k] = 0;
      m_ones[k] = 0; m_nb[k] = 0; m_cnt[k] = 0;
      m_bits[k] = '0; m_word[k] = '0;
    end else if (start) begin
      m_busy[k] = 1; m_ones[k] = 0; m_nb[k] = 0; m_mode[k] = odd;
    end else if (m_busy[k] && valid) begin
      if (m_nb[k] < dw[k]) begin
        m_bits[k][m_nb[k]] = x;
        m_ones[k] += int'(x);
        m_nb[k]++;
      end else begin
        e = (((m_ones[k] + int'(x)) % 2) != int'(m_mode[k]));
        m_done[k] = 1'b1;
        m_err[k]  = e;
        m_word[k] = m_bits[k];
        if (e && m_cnt[k] < ((1 << cw[k]) - 1)) m_cnt[k]++;
        m_busy[k] = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance model at the rising edge.
  task automatic step(input bit r, input bit st, input bit va, input bit xb, input bit od);
    rst = r; start = st; valid = va; x = xb; odd = od;
    @(negedge clk);
    check_inst(0, p0, busy0, done0, err0, 32'(cnt0), 32'(word0));
    check_inst(1, p1, busy1, done1, err1, 32'(cnt1), 32'(word1));
    check_inst(2, p2, busy2, done2, err2, 32'(cnt2), 32'(word2));
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    #1;
  endtask

  task automatic frame(input bit od, input logic [7:0] w, input bit par, input int gap);
    step(0, 1, 0, 0, od);
    for (int i = 0; i < 8; i++) begin
      repeat (gap) step(0, 0, 0, 0, 0);
      step(0, 0, 1, w[i], 0);
    end
    repeat (gap) step(0, 0, 0, 0, 0);
    step(0, 0, 1, par, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0; m_mode[k] = 0; m_done[k] = 0; m_err[k] = 0;
      m_ones[k] = 0; m_nb[k] = 0; m_cnt[k] = 0; m_bits[k] = '0; m_word[k] = '0;
    end
    rst = 1; start = 0; valid = 0; x = 0; odd = 0;
    @(posedge clk); #1;
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);

    frame(0, 8'hA5, 0, 0);
    frame(0, 8'hA5, 1, 0);
    frame(1, 8'h01, 0, 3);

    // Abort after four data bits, then a full frame.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
    frame(0, 8'hFF, 0, 0);

    // Counter saturation, then reset in the middle of a frame.
    for (int n = 0; n < 5; n++) frame(0, 8'h3C, 1, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);

    // Start and valid together: that bit is not taken.
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);

    // Back-to-back frame with start in the done cycle.
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1'(i), 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 1'(i + 1), 0);
    step(0, 0, 0, 0, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
